arb_mux_rr: RTL and testbench
=============================

# arb_mux_rr

Parametrised N-to-1 arbitrating multiplexer for the arbiter stage. It selects among N first-word-fall-through FIFOs and pops at most one word per cycle. The popped word is presented on a registered output with a valid flag and its source channel index. Arbitration is round-robin with optional burst hold, or fixed priority. It replaces the fixed 4x1 combinational mux and honours downstream back-pressure.

## Interface
- WIDTH, 10, data word width in bits (≥1)
- N, 4, number of input channels (≥2; need not be a power of two)
- BURST, 1, maximum consecutive pops granted to one channel in round-robin mode (≥1)
- SELW, $clog2(N), derived local parameter, width of channel index; not overridable

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- fifo_data  input  N*WIDTH  head word of each FIFO; channel i at [i*WIDTH +: WIDTH]
- fifo_empty  input  N  per-channel empty flag; 1 = no word available
- fifo_pop  output  N  one-hot or zero; pop strobe to the granted FIFO, combinational
- dest_almost_full  input  1  downstream back-pressure; 1 = no pop this cycle
- mode  input  1  0 = round-robin with burst, 1 = fixed priority (channel 0 highest)
- data_out  output  WIDTH  registered word popped in the previous cycle
- valid_out  output  1  registered; 1 = data_out/sel_out carry a new word this cycle
- sel_out  output  SELW  registered channel index of data_out

## Operation
- req[i] = ~fifo_empty[i]; arbitration allowed when reset=1 and dest_almost_full=0 and |req.
- Internal state:
  - ptr (SELW bits): next round-robin start channel.
  - owner (SELW bits): last granted channel.
  - burst_cnt: counts 0..BURST-1.
  - two-state FSM: IDLE (no grant last cycle) and HOLD (granted last cycle).
- Winner selection:
  - mode=1: lowest-index i with req[i].
  - mode=0, state HOLD, req[owner]=1 and burst_cnt < BURST-1: winner = owner (burst continues).
  - mode=0, otherwise: first i with req[i], searching ptr, ptr+1, … wrapping N-1→0.
- Grant: fifo_pop[winner]=1, all other bits 0. fifo_pop is all zero when arbitration is not allowed.
- On each clk edge with a grant:
  - data_out←fifo_data[winner], sel_out←winner, valid_out←1, owner←winner, state→HOLD.
  - burst_cnt←burst_cnt+1 if winner==owner and state was HOLD, else 0.
  - ptr←(winner+1) mod N, updated in both modes so that a switch to mode 0 remains fair.
- On each clk edge without a grant: valid_out←0, data_out and sel_out hold, state→IDLE, burst_cnt←0, ptr holds.
- When burst_cnt reaches BURST-1, the next grant must go to another requesting channel if one exists. If the owner is the only requester it is re-granted, with burst_cnt←0.
- BURST=1 gives pure round-robin.

## Timing
- Reset (reset=0, asynchronous): data_out=0, valid_out=0, sel_out=0, ptr=0, owner=0, burst_cnt=0, state=IDLE, fifo_pop=0 immediately.
- Reset deassertion takes effect at the first rising edge with reset=1. Reset mid-burst discards burst and pointer history; no pop is issued while reset=0.
- Latency: pop in cycle k → valid_out=1 with that word in cycle k+1. Throughput is one word per cycle.
- dest_almost_full is sampled combinationally. Asserting it suppresses fifo_pop in the same cycle, so valid_out=0 the next cycle. Already-registered data is unaffected.
- A channel going empty in the same cycle as its burst continuation is not granted. Selection falls through to the round-robin search.
- A mode change takes effect in the same cycle; no extra state is cleared.
- All fifo_empty=1: no pop, valid_out=0 next cycle.

## Test plan
- Reset: hold reset=0 with all FIFOs non-empty → fifo_pop=0, valid_out=0, data_out=0, sel_out=0. Release reset → first pop on channel 0, and next cycle data_out=10'h3C0, sel_out=0.
- Round-robin, N=4, BURST=1, all non-empty, data 10'h3C0/0E4/31B/2E7 → sel_out sequence 0,1,2,3,0… and data_out 3C0,0E4,31B,2E7,3C0; valid_out held at 1.
- Burst, BURST=3, all non-empty → sel_out 0,0,0,1,1,1,2,2,2,3…. With only channel 2 non-empty → sel_out 2 every cycle, no stall.
- Fixed priority: mode=1, channels 1 and 3 non-empty → sel_out=1 every cycle. Empty channel 1 → sel_out=3. Switch back to mode=0 → search starts at ptr.
- Back-pressure: dest_almost_full=1 for 3 cycles mid-stream → fifo_pop=0 in those cycles and valid_out=0 one cycle later. Sequence resumes at the next channel with no word lost or duplicated.
- Boundary: N=3, wrap from channel 2 to channel 0. Assert reset=0 mid-burst → outputs clear immediately, and after release arbitration restarts at channel 0.

Source files
------------

// File: rtl/arb_mux_rr.sv
// N-to-1 arbitrating mux draining first-word-fall-through FIFOs into a registered
// output; round-robin with burst hold (mode=0) or fixed priority, channel 0 first (mode=1).
module arb_mux_rr #(
    parameter int WIDTH = 10,
    parameter int N     = 4,
    parameter int BURST = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   fifo_data,
    input  logic [N-1:0]         fifo_empty,
    output logic [N-1:0]         fifo_pop,
    input  logic                 dest_almost_full,
    input  logic                 mode,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid_out,
    output logic [SELW-1:0]      sel_out
);

    localparam int CNTW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   owner_q, owner_d;
    logic [CNTW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic [SELW-1:0]   sel_q, sel_d;

    logic [N-1:0]      req;
    logic              allow;
    logic              cont;
    logic              found;
    logic              same_run;
    logic [SELW-1:0]   win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
        end
    end

    always_comb begin
        req      = ~fifo_empty;
        allow    = reset & ~dest_almost_full & (|req);
        cont     = (state_q == HOLD) && req[owner_q] && (int'(burst_cnt_q) < BURST - 1);
        found    = 1'b0;
        win      = '0;

        if (mode) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    found = 1'b1;
                    win   = SELW'(i);
                end
            end
        end else if (cont) begin
            win = owner_q;
        end else begin
            // Rotating search as two passes: channels at/after ptr, then the wrapped ones.
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (SELW'(i) >= ptr_q)) begin
                    found = 1'b1;
                    win   = SELW'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    found = 1'b1;
                    win   = SELW'(i);
                end
            end
        end

        fifo_pop = allow ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;

        same_run    = (state_q == HOLD) && (win == owner_q) && (int'(burst_cnt_q) < BURST - 1);
        state_d     = IDLE;
        burst_cnt_d = '0;
        valid_d     = 1'b0;
        data_d      = data_q;
        sel_d       = sel_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;

        if (allow) begin
            state_d     = HOLD;
            valid_d     = 1'b1;
            data_d      = fifo_data[int'(win)*WIDTH +: WIDTH];
            sel_d       = win;
            owner_d     = win;
            // A full burst wraps the count so a lone requester starts a fresh burst.
            burst_cnt_d = same_run ? burst_cnt_q + CNTW'(1) : '0;
            ptr_d       = (win == SELW'(N - 1)) ? '0 : win + SELW'(1);
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sel_out   = sel_q;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Randomized and directed bench for arb_mux_rr: three configurations share one stimulus
// and are checked against a grant-history model of the arbitration rules.
module tb_arb_mux_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic        daf;
    logic        mode;
    logic [3:0]  emp;
    logic [39:0] fdata;

    logic [3:0]  pop_a, pop_b;
    logic [2:0]  pop_c;
    logic [9:0]  d_a, d_b, d_c;
    logic        v_a, v_b, v_c;
    logic [1:0]  s_a, s_b, s_c;

    logic [3:0]  pop_w[3];
    logic [9:0]  d_w[3];
    logic        v_w[3];
    logic [1:0]  s_w[3];

    int n_chk  = 0;
    int n_pass = 0;

    // Configurations: A = N4/BURST1, B = N4/BURST3, C = N3/BURST2
    int NS[3] = '{4, 4, 3};
    int BS[3] = '{1, 3, 2};

    int   m_ptr[3], m_owner[3], m_run[3], m_sel[3], m_data[3], pick_w[3];
    bit   m_held[3], m_valid[3], pick_g[3];

    always #5 clk = ~clk;

    arb_mux_rr #(.WIDTH(10), .N(4), .BURST(1)) u_a (
        .clk(clk), .reset(reset), .fifo_data(fdata), .fifo_empty(emp), .fifo_pop(pop_a),
        .dest_almost_full(daf), .mode(mode), .data_out(d_a), .valid_out(v_a), .sel_out(s_a));
    arb_mux_rr #(.WIDTH(10), .N(4), .BURST(3)) u_b (
        .clk(clk), .reset(reset), .fifo_data(fdata), .fifo_empty(emp), .fifo_pop(pop_b),
        .dest_almost_full(daf), .mode(mode), .data_out(d_b), .valid_out(v_b), .sel_out(s_b));
    arb_mux_rr #(.WIDTH(10), .N(3), .BURST(2)) u_c (
        .clk(clk), .reset(reset), .fifo_data(fdata[29:0]), .fifo_empty(emp[2:0]), .fifo_pop(pop_c),
        .dest_almost_full(daf), .mode(mode), .data_out(d_c), .valid_out(v_c), .sel_out(s_c));

    assign pop_w[0] = pop_a;
    assign pop_w[1] = pop_b;
    assign pop_w[2] = {1'b0, pop_c};
    assign d_w[0] = d_a;
    assign d_w[1] = d_b;
    assign d_w[2] = d_c;
    assign v_w[0] = v_a;
    assign v_w[1] = v_b;
    assign v_w[2] = v_c;
    assign s_w[0] = s_a;
    assign s_w[1] = s_b;
    assign s_w[2] = s_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_ptr[m] = 0; m_owner[m] = 0; m_run[m] = 0; m_held[m] = 0;
            m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0;
        end
    endtask

    // Winner from the rules: priority scan, burst continuation, or rotating search from ptr.
    task automatic model_pick(input int m);
        int n, b, idx;
        logic [3:0] req;
        n = NS[m];
        b = BS[m];
        req = '0;
        for (int i = 0; i < n; i++) req[i] = ~emp[i];
        pick_g[m] = 0;
        pick_w[m] = 0;
        if (!reset || daf || req == 4'd0) return;
        pick_g[m] = 1;
        if (mode) begin
            for (int i = n - 1; i >= 0; i--) if (req[i]) pick_w[m] = i;
        end else if (m_held[m] && req[m_owner[m]] && m_run[m] < b) begin
            pick_w[m] = m_owner[m];
        end else begin
            for (int k = n - 1; k >= 0; k--) begin
                idx = (m_ptr[m] + k) % n;
                if (req[idx]) pick_w[m] = idx;
            end
        end
    endtask

    // m_run counts grants in the current burst (1..BURST).
    task automatic model_commit(input int m);
        int w;
        if (!reset) begin
            m_ptr[m] = 0; m_owner[m] = 0; m_run[m] = 0; m_held[m] = 0;
            m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0;
        end else if (pick_g[m]) begin
            w = pick_w[m];
            m_run[m]   = (m_held[m] && w == m_owner[m] && m_run[m] < BS[m]) ? m_run[m] + 1 : 1;
            m_owner[m] = w;
            m_held[m]  = 1;
            m_ptr[m]   = (w + 1) % NS[m];
            m_valid[m] = 1;
            m_data[m]  = int'(fdata[w*10 +: 10]);
            m_sel[m]   = w;
        end else begin
            m_valid[m] = 0;
            m_held[m]  = 0;
            m_run[m]   = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        for (int m = 0; m < 3; m++) begin
            model_pick(m);
            chk($sformatf("pop%0d", m), 32'(pop_w[m]),
                pick_g[m] ? 32'(1) << pick_w[m] : 32'd0);
        end
        @(posedge clk);
        for (int m = 0; m < 3; m++) model_commit(m);
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("valid%0d", m), 32'(v_w[m]), 32'(m_valid[m]));
            chk($sformatf("data%0d", m), 32'(d_w[m]), 32'(m_data[m]));
            chk($sformatf("sel%0d", m), 32'(s_w[m]), 32'(m_sel[m]));
        end
    endtask

    task automatic set_fixed_data();
        fdata = {10'h2E7, 10'h31B, 10'h0E4, 10'h3C0};
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_b[8] = '{0, 0, 0, 1, 1, 1, 2, 2};
        int exp_c[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        int dat[4]   = '{'h3C0, 'h0E4, 'h31B, 'h2E7};

        reset = 1'b0; daf = 1'b0; mode = 1'b0; emp = 4'b0000;
        set_fixed_data();
        model_reset();

        // Reset held with every FIFO non-empty
        @(negedge clk);
        for (int c = 0; c < 3; c++) step();
        chk("rst_valid", 32'(v_a), 32'd0);
        chk("rst_data", 32'(d_a), 32'd0);

        // Release: round-robin / burst / wrap sequences
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_sel_a", 32'(s_a), 32'(exp_a[c]));
            chk("rr_data_a", 32'(d_a), 32'(dat[exp_a[c]]));
            chk("burst_sel_b", 32'(s_b), 32'(exp_b[c]));
            chk("wrap_sel_c", 32'(s_c), 32'(exp_c[c]));
        end

        // Lone requester keeps being granted without stall
        emp = 4'b1011;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("lone_sel_b", 32'(s_b), 32'd2);
            chk("lone_valid_b", 32'(v_b), 32'd1);
        end

        // Fixed priority, then losing the top requester, then back to round-robin
        mode = 1'b1; emp = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("prio_sel_a", 32'(s_a), 32'd1);
        end
        emp = 4'b0111;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("prio3_sel_a", 32'(s_a), 32'd3);
        end
        mode = 1'b0; emp = 4'b0000;
        step();
        chk("mode_back_sel_a", 32'(s_a), 32'd0);

        // Back-pressure mid-stream
        for (int c = 0; c < 2; c++) step();
        daf = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_valid_a", 32'(v_a), 32'd0);
        end
        daf = 1'b0;
        for (int c = 0; c < 4; c++) step();

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            fdata[39:32] = 8'($urandom);
            fdata[31:0]  = $urandom;
            emp  = 4'($urandom) & 4'($urandom);
            daf  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            step();
        end

        // Asynchronous reset mid-burst
        daf = 1'b0; mode = 1'b0; emp = 4'b0000;
        set_fixed_data();
        for (int c = 0; c < 2; c++) step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_pop_a", 32'(pop_a), 32'd0);
        chk("arst_pop_c", 32'(pop_c), 32'd0);
        chk("arst_valid_b", 32'(v_b), 32'd0);
        chk("arst_data_b", 32'(d_b), 32'd0);
        chk("arst_sel_a", 32'(s_a), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("post_rst_sel_b", 32'(s_b), 32'(exp_b[c]));
            chk("post_rst_sel_a", 32'(s_a), 32'(exp_a[c]));
        end

        // More random traffic after the restart
        for (int c = 0; c < 100; c++) begin
            fdata[39:32] = 8'($urandom);
            fdata[31:0]  = $urandom;
            emp  = 4'($urandom) & 4'($urandom);
            daf  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
